vc_credit_scheduler: RTL and testbench
======================================

# vc_credit_scheduler

Credit-based scheduler that sequences the four virtual-channel source FIFOs (VC0/VC1 of port 0 and port 1) onto one shared output link. Each cycle it selects at most one non-empty FIFO whose VC holds downstream credit, pops it, and registers the word onto the link. VC0 has strict priority over VC1, bounded by an anti-starvation limit; within a VC the two ports are served round-robin. The block sits between the input VC FIFOs and the downstream link FIFOs, in place of a free-running pop arbiter.

## Interface
- DATA_W, 5: width of one data word.
- CREDITS_MAX, 4: downstream buffer depth per VC; credit counter reload and saturation value.
- CRED_W, 3: credit counter width; must hold CREDITS_MAX.
- STARVE_LIM, 3: maximum consecutive VC0 grants while VC1 is eligible.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  grants are allowed only while high.
- empty  in  4  FIFO empty flags. Index 0=VC0_p0, 1=VC1_p0, 2=VC0_p1, 3=VC1_p1.
- data_in  in  4*DATA_W  show-ahead FIFO heads. Source i occupies bits [i*DATA_W +: DATA_W].
- credit_ret  in  2  one-cycle credit return pulses, per VC (bit 0=VC0, bit 1=VC1).
- pop  out  4  combinational pop strobes; at most one bit is high.
- data_out  out  DATA_W  registered output word.
- valid_out  out  1  registered; data_out is valid.
- vc_out  out  1  registered VC of data_out.
- port_out  out  1  registered source port of data_out.
- credits_vc0, credits_vc1  out  CRED_W  current credit counts.
- credit_err  out  1  sticky flag; set on a credit return that would overflow.

## Operation
- FSM states:
  - INIT: entered while reset is high. Credits are 0 and pop is 0.
  - INIT→RUN: on the first edge with reset low. Both credit counters load CREDITS_MAX.
  - RUN: stays in RUN until reset.
- Eligibility: source i is eligible iff state=RUN, enable=1, empty[i]=0, and the credit counter of its VC is nonzero.
- VC choice:
  - VC0 wins if any VC0 source is eligible.
  - Exception: grant VC1 when starve_cnt=STARVE_LIM and a VC1 source is eligible.
- Port choice within the chosen VC:
  - Each VC has its own pointer, rr_vc0 or rr_vc1, naming the favored port.
  - The favored port wins if eligible; otherwise the other port wins.
  - After a grant to port p on VC v, rr_v is set to the other port (~p).
  - Pointers reset to port 0.
- starve_cnt (width sized to STARVE_LIM):
  - Increments on a VC0 grant while a VC1 source is eligible.
  - Clears on any VC1 grant, and in any cycle with no VC1 source eligible.
  - Holds otherwise.
- Credits, per VC v: next = cur − grant_v + credit_ret[v].
  - A grant and a return in the same cycle leave the counter unchanged.
  - A return when cur=CREDITS_MAX with no grant: the counter stays at CREDITS_MAX and credit_err is set.
  - A zero-credit VC is never granted, so the counter cannot underflow.
- credit_ret pulses are ignored in INIT.
- credit_err clears only on reset.

## Timing
- pop is combinational from registered state plus empty, enable, and the credits; it is asserted in grant cycle N.
- The FIFO advances on the edge ending cycle N. In cycle N+1, data_out holds data_in of source i as sampled in cycle N, with valid_out=1, vc_out and port_out set. Latency is 1 cycle.
- Without a grant in cycle N, valid_out=0 in cycle N+1. data_out and vc_out hold their last values.
- Sustained throughput: one word per cycle while credit and data are available.
- Reset values: pop=0, valid_out=0, data_out=0, vc_out=0, port_out=0, credits=0, credit_err=0, starve_cnt=0, rr pointers=0.
- First possible pop: the second cycle after reset falls, i.e. the first RUN cycle.
- Reset mid-operation: the word in flight is dropped (valid_out=0 on the next edge), and credits return to 0 and then reload through INIT.
- Deasserting enable blocks pop in that same cycle. A valid_out already registered still appears.

## Test plan
- Reset, then 2 idle cycles:
  - While reset is high: credits 0 and pop 0.
  - After the first edge with reset low: credits = 4.
  - valid_out stays 0 throughout.
- Round-robin within VC0: VC0_p0 and VC0_p1 each hold 3 words, credit_ret pulses each cycle.
  - Required pop sequence: 0001, 0100, 0001, 0100, 0001, 0100.
  - Each word appears on data_out one cycle after its pop, with vc_out=0 and port_out alternating 0,1.
- Credit exhaustion: only VC0_p0 non-empty with 10 words, no credit_ret.
  - Exactly 4 pops, then credits_vc0=0 and pop=0.
  - One credit_ret[0] pulse produces exactly one more pop, in the following cycle.
- Anti-starvation: all four FIFOs are full, and credit_ret=11 every cycle.
  - Required grant VC pattern: 0,0,0,1,0,0,0,1.
  - VC1 ports alternate p0, p1.
- Simultaneous credit events and overflow:
  - A grant on VC1 plus credit_ret[1] in the same cycle keeps credits_vc1 constant.
  - credit_ret[0] with credits_vc0=4 and no grant keeps the count at 4 and sets credit_err, which stays set until reset.
- Reset mid-burst: assert reset in the cycle after a pop.
  - valid_out=0 after the reset edge and credits return to 0.
  - After reset is released: reload to 4, and no pop before the first RUN cycle.

Source files
------------

// File: rtl/vc_credit_scheduler.sv
// ---------------------------------------------------------------------------
// vc_credit_scheduler
//
// Credit-based scheduler for four virtual-channel source FIFOs that share one
// output link. Each cycle it pops at most one non-empty FIFO whose VC still
// holds downstream credit. The popped word is registered onto the link.
//
// Arbitration:
//   - VC0 has strict priority over VC1.
//   - An anti-starvation counter forces a VC1 grant after STARVE_LIM
//     consecutive VC0 grants that were made while VC1 was also eligible.
//   - Within each VC, a per-VC round-robin pointer alternates between the
//     two ports.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   enable      grants are allowed only while high
//   empty[3:0]  FIFO empty flags: 0=VC0_p0, 1=VC1_p0, 2=VC0_p1, 3=VC1_p1
//   data_in     show-ahead FIFO heads; source i is data_in[i*DATA_W +: DATA_W]
//   credit_ret  one-cycle credit return pulses, bit 0=VC0, bit 1=VC1
//   pop         combinational one-hot (or zero) pop strobes
//   data_out    registered link word
//   valid_out   registered; data_out is valid this cycle
//   vc_out      registered VC of data_out
//   port_out    registered source port of data_out
//   credits_vc0 current VC0 credit count
//   credits_vc1 current VC1 credit count
//   credit_err  sticky; a credit return arrived with the counter already full
// ---------------------------------------------------------------------------
module vc_credit_scheduler #(
    parameter int DATA_W      = 5,
    parameter int CREDITS_MAX = 4,
    parameter int CRED_W      = 3,
    parameter int STARVE_LIM  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [3:0]            empty,
    input  logic [4*DATA_W-1:0]   data_in,
    input  logic [1:0]            credit_ret,
    output logic [3:0]            pop,
    output logic [DATA_W-1:0]     data_out,
    output logic                  valid_out,
    output logic                  vc_out,
    output logic                  port_out,
    output logic [CRED_W-1:0]     credits_vc0,
    output logic [CRED_W-1:0]     credits_vc1,
    output logic                  credit_err
);

    localparam int                  STARVE_W  = $clog2(STARVE_LIM + 1);
    localparam logic [CRED_W-1:0]   CRED_FULL = CRED_W'(CREDITS_MAX);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIM);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                   state_q, state_d;
    logic [1:0][CRED_W-1:0]   cred_q, cred_d;     // index = VC
    logic [1:0]               rr_q, rr_d;         // bit v = favored port of VC v
    logic [STARVE_W-1:0]      starve_q, starve_d;
    logic                     err_q, err_d;
    logic                     valid_q, valid_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic                     vc_q, vc_d;
    logic                     port_q, port_d;

    logic [DATA_W-1:0]        src_word [4];
    logic [3:0]               elig;
    logic                     can_grant;
    logic                     any_vc0, any_vc1;
    logic                     grant, g_vc, g_port;
    logic                     p0_ok, p1_ok;
    logic [1:0]               g_idx;
    logic [1:0]               grant_v;

    // Arbitration: which source (if any) is popped this cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            src_word[i] = data_in[i*DATA_W +: DATA_W];
        end

        // Reset gates grants so pop is held low for the whole reset cycle.
        can_grant = (state_q == ST_RUN) && !reset && enable;
        elig[0]   = can_grant && !empty[0] && (cred_q[0] != '0);
        elig[1]   = can_grant && !empty[1] && (cred_q[1] != '0);
        elig[2]   = can_grant && !empty[2] && (cred_q[0] != '0);
        elig[3]   = can_grant && !empty[3] && (cred_q[1] != '0);

        any_vc0 = elig[0] | elig[2];
        any_vc1 = elig[1] | elig[3];
        grant   = any_vc0 | any_vc1;

        // VC1 wins when VC0 is idle, or when VC1 has waited STARVE_LIM grants.
        g_vc  = any_vc1 && (!any_vc0 || (starve_q == STARVE_TOP));
        p0_ok = g_vc ? elig[1] : elig[0];
        p1_ok = g_vc ? elig[3] : elig[2];

        // Favored port if it can go, otherwise the other one.
        g_port = rr_q[g_vc] ? p1_ok : !p0_ok;
        g_idx  = {g_port, g_vc};

        pop     = grant ? (4'b0001 << g_idx) : 4'b0000;
        grant_v = grant ? (g_vc ? 2'b10 : 2'b01) : 2'b00;
    end

    // Next-state: FSM, credits, pointers, starvation counter, output word.
    always_comb begin
        // NOTE: every signal gets a default here so no path through the
        // branches below leaves it unassigned and infers a latch.
        state_d  = state_q;
        cred_d   = cred_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        err_d    = err_q;
        valid_d  = grant;
        data_d   = data_q;
        vc_d     = vc_q;
        port_d   = port_q;

        if (grant) begin
            data_d       = src_word[g_idx];
            vc_d         = g_vc;
            port_d       = g_port;
            rr_d[g_vc]   = !g_port;
        end

        case (state_q)
            ST_INIT: begin
                // Credit returns are ignored here; both counters reload.
                state_d   = ST_RUN;
                cred_d[0] = CRED_FULL;
                cred_d[1] = CRED_FULL;
            end
            ST_RUN: begin
                for (int v = 0; v < 2; v++) begin
                    if (grant_v[v] && !credit_ret[v]) begin
                        cred_d[v] = cred_q[v] - CRED_W'(1);
                    end else if (!grant_v[v] && credit_ret[v]) begin
                        // A return into a full counter is dropped and flagged.
                        if (cred_q[v] == CRED_FULL) begin
                            err_d = 1'b1;
                        end else begin
                            cred_d[v] = cred_q[v] + CRED_W'(1);
                        end
                    end
                end

                if (grant && !g_vc && any_vc1) begin
                    starve_d = starve_q + STARVE_W'(1);
                end else if ((grant && g_vc) || !any_vc1) begin
                    starve_d = '0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q  <= ST_INIT;
            cred_q   <= '0;
            rr_q     <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            vc_q     <= 1'b0;
            port_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cred_q   <= cred_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            vc_q     <= vc_d;
            port_q   <= port_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign vc_out      = vc_q;
    assign port_out    = port_q;
    assign credits_vc0 = cred_q[0];
    assign credits_vc1 = cred_q[1];
    assign credit_err  = err_q;

endmodule

// File: tb/tb_vc_credit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vc_credit_scheduler
//
// Drives the scheduler from four behavioural FIFOs and predicts every grant
// with a reference model built from the arbitration rules (integer credits,
// per-VC favored port, starvation count). Predicted link words go into a
// scoreboard that an independent monitor drains one cycle later.
// ---------------------------------------------------------------------------
module tb_vc_credit_scheduler;

    localparam int DATA_W      = 5;
    localparam int CREDITS_MAX = 4;
    localparam int CRED_W      = 3;
    localparam int STARVE_LIM  = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [3:0]            empty;
    logic [4*DATA_W-1:0]   data_in;
    logic [1:0]            credit_ret;
    logic [3:0]            pop;
    logic [DATA_W-1:0]     data_out;
    logic                  valid_out;
    logic                  vc_out;
    logic                  port_out;
    logic [CRED_W-1:0]     credits_vc0;
    logic [CRED_W-1:0]     credits_vc1;
    logic                  credit_err;

    vc_credit_scheduler #(
        .DATA_W      (DATA_W),
        .CREDITS_MAX (CREDITS_MAX),
        .CRED_W      (CRED_W),
        .STARVE_LIM  (STARVE_LIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .empty       (empty),
        .data_in     (data_in),
        .credit_ret  (credit_ret),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .vc_out      (vc_out),
        .port_out    (port_out),
        .credits_vc0 (credits_vc0),
        .credits_vc1 (credits_vc1),
        .credit_err  (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              vc;
        logic              port;
    } exp_t;

    // Behavioural source FIFOs
    logic [DATA_W-1:0] fmem [4][64];
    int                fhead [4];
    int                fcnt  [4];

    // Reference model state
    bit  m_run;
    int  m_cred [2];
    int  m_rr [2];
    int  m_starve;
    bit  m_err;

    exp_t              sb[$];
    logic [3:0]        pop_hist[$];
    logic [DATA_W-1:0] last_data;
    logic              last_vc;

    int  n_vec;
    int  n_err;
    bit  done;
    int  n_pops;
    logic [3:0] rr_seq [6];
    bit         starve_seq [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fifo_fill(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            if (fcnt[src] < 60) begin
                fmem[src][(fhead[src] + fcnt[src]) % 64] = DATA_W'($urandom);
                fcnt[src]++;
            end
        end
    endtask

    task automatic fifo_clear_all();
        for (int s = 0; s < 4; s++) fcnt[s] = 0;
    endtask

    // One clock cycle: apply inputs, predict and check the grant, advance model.
    task automatic step(input logic rst, input logic en, input logic [1:0] ret);
        bit   el [4];
        bit   any0, any1;
        int   src, v, fav, p;
        exp_t e;

        reset      = rst;
        enable     = en;
        credit_ret = ret;
        for (int i = 0; i < 4; i++) begin
            empty[i] = (fcnt[i] == 0);
            data_in[i*DATA_W +: DATA_W] = (fcnt[i] != 0) ? fmem[i][fhead[i]] : '0;
        end

        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            el[i] = !rst && m_run && en && (fcnt[i] != 0) && (m_cred[i % 2] > 0);
        end
        any0 = el[0] || el[2];
        any1 = el[1] || el[3];
        src  = -1;
        if (any0 || any1) begin
            v   = (any1 && (!any0 || m_starve == STARVE_LIM)) ? 1 : 0;
            fav = m_rr[v];
            p   = el[v + 2*fav] ? fav : 1 - fav;
            src = v + 2*p;
        end

        check("pop", pop, (src < 0) ? 0 : (1 << src));
        check("credits_vc0", credits_vc0, m_cred[0]);
        check("credits_vc1", credits_vc1, m_cred[1]);
        check("credit_err", credit_err, m_err);
        pop_hist.push_back(pop);

        if (src >= 0) begin
            e.data = fmem[src][fhead[src]];
            e.vc   = (src % 2) == 1;
            e.port = (src / 2) == 1;
            sb.push_back(e);
            fhead[src] = (fhead[src] + 1) % 64;
            fcnt[src]--;
        end

        if (rst) begin
            m_run     = 0;
            m_cred    = '{0, 0};
            m_rr      = '{0, 0};
            m_starve  = 0;
            m_err     = 0;
            last_data = '0;
            last_vc   = 1'b0;
        end else if (!m_run) begin
            m_run  = 1;
            m_cred = '{CREDITS_MAX, CREDITS_MAX};
        end else begin
            for (int w = 0; w < 2; w++) begin
                m_cred[w] += int'(ret[w]) - ((src >= 0 && src % 2 == w) ? 1 : 0);
                if (m_cred[w] > CREDITS_MAX) begin
                    m_cred[w] = CREDITS_MAX;
                    m_err     = 1;
                end
            end
            if (src >= 0) m_rr[src % 2] = 1 - src / 2;
            if (src >= 0 && src % 2 == 0 && any1)          m_starve++;
            else if ((src >= 0 && src % 2 == 1) || !any1)  m_starve = 0;
        end

        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the registered link against the scoreboard.
    initial begin : monitor
        exp_t e;
        bit   exp_v;
        @(posedge clk);
        while (!done) begin
            @(posedge clk);
            #2;
            exp_v = (sb.size() != 0);
            check("valid_out", valid_out, exp_v);
            if (exp_v) begin
                e = sb.pop_front();
                check("data_out", data_out, e.data);
                check("vc_out", vc_out, e.vc);
                check("port_out", port_out, e.port);
                last_data = e.data;
                last_vc   = e.vc;
            end else begin
                check("data_out_hold", data_out, last_data);
                check("vc_out_hold", vc_out, last_vc);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic       en_r;
        logic [1:0] ret_r;

        reset      = 1'b1;
        enable     = 1'b0;
        credit_ret = 2'b00;
        empty      = 4'b1111;
        data_in    = '0;
        for (int s = 0; s < 4; s++) begin
            fhead[s] = 0;
            fcnt[s]  = 0;
        end
        m_run = 0; m_cred = '{0, 0}; m_rr = '{0, 0}; m_starve = 0; m_err = 0;
        last_data = '0; last_vc = 1'b0;
        n_vec = 0; n_err = 0; done = 0;
        rr_seq     = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100};
        starve_seq = '{0, 0, 0, 1, 0, 0, 0, 1};

        @(posedge clk);
        #1;

        // Reset held, then release into INIT and two idle RUN cycles.
        repeat (2) step(1'b1, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        check("reload_vc0", credits_vc0, CREDITS_MAX);
        check("reload_vc1", credits_vc1, CREDITS_MAX);

        // Return into a full counter: count holds, sticky error sets.
        check("err_clear", credit_err, 0);
        step(1'b0, 1'b1, 2'b01);
        check("ovf_hold_vc0", credits_vc0, CREDITS_MAX);
        check("err_set", credit_err, 1);

        // Round-robin within VC0.
        fifo_fill(0, 3);
        fifo_fill(2, 3);
        pop_hist.delete();
        repeat (6) step(1'b0, 1'b1, 2'b01);
        for (int k = 0; k < 6; k++) check("rr_pop_seq", pop_hist[k], rr_seq[k]);
        step(1'b0, 1'b1, 2'b00);

        // Credit exhaustion on VC0, then a single return.
        fifo_fill(0, 10);
        pop_hist.delete();
        repeat (6) step(1'b0, 1'b1, 2'b00);
        n_pops = 0;
        foreach (pop_hist[k]) if (pop_hist[k] != 4'b0000) n_pops++;
        check("exhaust_pops", n_pops, 4);
        check("exhaust_cred", credits_vc0, 0);
        pop_hist.delete();
        step(1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        check("ret_cycle_pop", pop_hist[0], 4'b0000);
        check("after_ret_pop", pop_hist[1], 4'b0001);
        check("after_ret_idle", pop_hist[2], 4'b0000);
        fifo_clear_all();
        repeat (4) step(1'b0, 1'b1, 2'b01);

        // Anti-starvation with every FIFO loaded and both credits returning.
        for (int s = 0; s < 4; s++) fifo_fill(s, 16);
        pop_hist.delete();
        repeat (8) step(1'b0, 1'b1, 2'b11);
        for (int k = 0; k < 8; k++) begin
            check("starve_vc_seq", pop_hist[k][1] | pop_hist[k][3], starve_seq[k]);
        end
        check("vc1_first_port", pop_hist[3], 4'b0010);
        check("vc1_second_port", pop_hist[7], 4'b1000);
        check("vc1_cred_const", credits_vc1, CREDITS_MAX);
        check("err_sticky", credit_err, 1);
        fifo_clear_all();
        step(1'b0, 1'b1, 2'b00);

        // Randomised traffic, credit returns and enable.
        repeat (300) begin
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(0, 3) == 0) fifo_fill(s, $urandom_range(1, 3));
            end
            ret_r[0] = ($urandom_range(0, 2) == 0);
            ret_r[1] = ($urandom_range(0, 2) == 0);
            en_r     = ($urandom_range(0, 7) != 0);
            step(1'b0, en_r, ret_r);
        end

        // Reset in the cycle after a pop.
        fifo_clear_all();
        repeat (4) step(1'b0, 1'b1, 2'b11);
        fifo_fill(1, 4);
        pop_hist.delete();
        step(1'b0, 1'b1, 2'b00);
        step(1'b1, 1'b1, 2'b00);
        check("mid_reset_pop", pop_hist[0], 4'b0010);
        check("mid_reset_hold_pop", pop_hist[1], 4'b0000);
        check("mid_reset_valid", valid_out, 0);
        check("mid_reset_cred_vc1", credits_vc1, 0);
        check("mid_reset_err", credit_err, 0);
        step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        check("init_no_pop", pop_hist[2], 4'b0000);
        check("first_run_pop", pop_hist[3], 4'b0010);
        fifo_clear_all();
        repeat (2) step(1'b0, 1'b1, 2'b00);

        @(posedge clk);
        #3;
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
